io_timer: RTL and testbench



---
 rtl/io_timer_pkg.sv | 22 ++
 rtl/io_timer_prescaler.sv | 18 +
 rtl/io_timer.sv | 83 ++++++++
 tb/tb_io_timer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/io_timer_pkg.sv
// io_timer_pkg: register map, control bit positions and control register layout
package io_timer_pkg;
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STAT   = 3'd1;
  localparam logic [2:0] REG_CMP_L  = 3'd2;
  localparam logic [2:0] REG_CMP_H  = 3'd3;
  localparam logic [2:0] REG_SNAP_L = 3'd4;
  localparam logic [2:0] REG_SNAP_H = 3'd5;
  localparam logic [2:0] REG_PRESC  = 3'd6;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_LATCH  = 2;
  localparam int CTRL_CLR    = 3;
  localparam int STAT_PEND   = 0;
  typedef struct packed {
    logic [3:0] rsvd;
    logic       clr;
    logic       latch;
    logic       irq_en;
    logic       en;
  } ctrl_t;
endpackage

// File: rtl/io_timer_prescaler.sv
// io_timer_prescaler: divides clk_i by presc+1 while enabled, emitting one-cycle ticks
module io_timer_prescaler (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] presc,
  output logic       tick
);
  logic [7:0] cnt;
  // >= so that lowering presc mid-count ends the period at once instead of wrapping through 255
  assign tick = en & (cnt >= presc);
  // count 0..presc, restart after each tick; clr and reset zero the count
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) cnt <= 8'd0;
    else if (en) cnt <= tick ? 8'd0 : cnt + 8'd1;
  end
endmodule

// File: rtl/io_timer.sv
// io_timer: 16-bit compare timer on the core IO bus; IO_TIMER_AUTORELOAD_EN selects periodic mode
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] io_addr_i,
  input  logic [7:0] io_data_i,
  input  logic       io_we_i,
  output logic [7:0] io_data_o,
  output logic       irq_o
);
`ifdef IO_TIMER_AUTORELOAD_EN
  localparam bit ONE_SHOT = 1'b0;
`else
  localparam bit ONE_SHOT = 1'b1;
`endif
  ctrl_t       ctrl;
  logic [7:0]  off, stage, presc;
  logic [15:0] cmp, cnt, snap;
  logic        hit, we, wr_ctrl, wr_stat, wr_cmp_l, wr_cmp_h, wr_presc;
  logic        pend, tick, clr, latch, match;
  // addresses below BASE_ADDR wrap to large offsets, so one compare bounds the window
  assign off      = io_addr_i - BASE_ADDR;
  assign hit      = off < 8'd7;
  assign we       = io_we_i & hit;
  assign wr_ctrl  = we & (off[2:0] == REG_CTRL);
  assign wr_stat  = we & (off[2:0] == REG_STAT);
  assign wr_cmp_l = we & (off[2:0] == REG_CMP_L);
  assign wr_cmp_h = we & (off[2:0] == REG_CMP_H);
  assign wr_presc = we & (off[2:0] == REG_PRESC);
  assign clr      = wr_ctrl & io_data_i[CTRL_CLR];
  assign latch    = wr_ctrl & io_data_i[CTRL_LATCH];
  assign match    = tick & ~clr & (cnt == cmp);
  assign irq_o    = pend & ctrl.irq_en;
  io_timer_prescaler u_presc (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en(ctrl.en),
    .clr(clr),
    .presc(presc),
    .tick(tick)
  );
  // register file, counter and pending flag; a match beats W1C, clr beats a tick
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl  <= '0;
      pend  <= 1'b0;
      stage <= 8'h00;
      cmp   <= 16'h0000;
      presc <= 8'h00;
      cnt   <= 16'h0000;
      snap  <= 16'h0000;
    end else begin
      if (wr_ctrl) ctrl <= '{rsvd: 4'h0, clr: 1'b0, latch: 1'b0, irq_en: io_data_i[CTRL_IRQ_EN], en: io_data_i[CTRL_EN]};
      else if (match && ONE_SHOT) ctrl.en <= 1'b0;
      pend <= match | (pend & ~(wr_stat & io_data_i[STAT_PEND]));
      if (wr_cmp_l) stage <= io_data_i;
      if (wr_cmp_h) cmp <= {io_data_i, stage};
      if (wr_presc) presc <= io_data_i;
      if (latch) snap <= cnt;
      if (clr || match) cnt <= 16'h0000;
      else if (tick) cnt <= cnt + 16'd1;
    end
  end
  // side-effect-free read mux, zero outside the decoded window
  always_comb begin
    io_data_o = 8'h00;
    if (hit)
      case (off[2:0])
        REG_CTRL:   io_data_o = ctrl;
        REG_STAT:   io_data_o = {7'b0, pend};
        REG_CMP_L:  io_data_o = cmp[7:0];
        REG_CMP_H:  io_data_o = cmp[15:8];
        REG_SNAP_L: io_data_o = snap[7:0];
        REG_SNAP_H: io_data_o = snap[15:8];
        REG_PRESC:  io_data_o = presc;
        default:    io_data_o = 8'h00;
      endcase
  end
endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed self-checking bench for io_timer
module tb_io_timer;
`ifdef IO_TIMER_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam logic [7:0] BASE = 8'h10;
  logic       clk = 1'b0;
  logic       rst, we, irq;
  logic [7:0] addr, din, dout;
  int         n_chk = 0;
  int         n_err = 0;
  io_timer #(.BASE_ADDR(BASE)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .io_addr_i(addr),
    .io_data_i(din),
    .io_we_i(we),
    .io_data_o(dout),
    .irq_o(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] off, input logic [7:0] d);
    addr = BASE + off;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask
  task automatic peek(input string tag, input logic [7:0] off, input logic [7:0] exp);
    addr = BASE + off;
    #1;
    check(tag, {8'h00, dout}, {8'h00, exp});
  endtask
  task automatic stop;
    wr(8'd0, 8'h08);
    wr(8'd1, 8'h01);
  endtask
  initial begin
    rst = 1'b1; we = 1'b0; addr = 8'h00; din = 8'h00;
    cyc(3);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      peek($sformatf("rst_off%0d", i), i[7:0], 8'h00);
      if (i == 3) cyc(1);
    end
    check("rst_irq", {15'h0, irq}, 16'h0000);
    wr(8'd7, 8'hFF);
    peek("unmapped_wr", 8'd7, 8'h00);
    peek("unmapped_ctrl", 8'd0, 8'h00);
    wr(8'd6, 8'h00); wr(8'd2, 8'h03); wr(8'd3, 8'h00); wr(8'd0, 8'h03);
    check("irq_start", {15'h0, irq}, 16'h0000);
    cyc(3);
    check("irq_before", {15'h0, irq}, 16'h0000);
    cyc(1);
    check("irq_rise", {15'h0, irq}, 16'h0001);
    wr(8'd1, 8'h01);
    check("irq_w1c", {15'h0, irq}, 16'h0000);
    peek("mode_en", 8'd0, AUTO ? 8'h03 : 8'h02);
    stop;
    wr(8'd6, 8'h04); wr(8'd2, 8'h01); wr(8'd3, 8'h00); wr(8'd0, 8'h01);
    cyc(9);
    peek("presc_pre", 8'd1, 8'h00);
    cyc(1);
    peek("presc_match", 8'd1, 8'h01);
    wr(8'd1, 8'h01);
    peek("presc_w1c", 8'd1, 8'h00);
    cyc(8);
    peek("period_pre", 8'd1, 8'h00);
    cyc(1);
    peek("period_match", 8'd1, AUTO ? 8'h01 : 8'h00);
    peek("period_en", 8'd0, AUTO ? 8'h01 : 8'h00);
    stop;
    wr(8'd0, 8'h01);
    cyc(9);
    wr(8'd1, 8'h01);
    peek("w1c_race", 8'd1, 8'h01);
    stop;
    wr(8'd2, 8'h00); wr(8'd3, 8'h00); wr(8'd2, 8'hAA);
    peek("stage_l", 8'd2, 8'h00);
    peek("stage_h", 8'd3, 8'h00);
    wr(8'd3, 8'h55);
    peek("commit_l", 8'd2, 8'hAA);
    peek("commit_h", 8'd3, 8'h55);
    stop;
    wr(8'd6, 8'h00); wr(8'd2, 8'hFF); wr(8'd3, 8'h00); wr(8'd0, 8'h01);
    cyc(4);
    wr(8'd0, 8'h05);
    peek("snap_l", 8'd4, 8'h04);
    peek("snap_h", 8'd5, 8'h00);
    cyc(3);
    peek("snap_stable", 8'd4, 8'h04);
    wr(8'd0, 8'h05);
    peek("snap_adv", 8'd4, 8'h08);
    stop;
    wr(8'd2, 8'h02); wr(8'd3, 8'h00); wr(8'd0, 8'h01);
    cyc(2);
    wr(8'd0, 8'h09);
    peek("clr_no_pend", 8'd1, 8'h00);
    wr(8'd0, 8'h05);
    peek("clr_cnt", 8'd4, 8'h00);
    peek("clr_en_kept", 8'd0, 8'h01);
    stop;
    wr(8'd6, 8'h03); wr(8'd2, 8'h00); wr(8'd3, 8'h00); wr(8'd0, 8'h03);
    cyc(5);
    check("pre_rst_irq", {15'h0, irq}, 16'h0001);
    wr(8'd2, 8'h20); wr(8'd3, 8'h00); wr(8'd0, 8'h03);
    cyc(10);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    check("mid_rst_irq", {15'h0, irq}, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      peek($sformatf("mid_rst_off%0d", i), i[7:0], 8'h00);
      if (i == 3) cyc(1);
    end
    wr(8'd0, 8'h04);
    peek("mid_rst_cnt_l", 8'd4, 8'h00);
    peek("mid_rst_cnt_h", 8'd5, 8'h00);
    cyc(5);
    check("mid_rst_irq_late", {15'h0, irq}, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
